// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory port between fetch (F) and data (D).
// Define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT BUSY cycles without mem_rdy.
module mem_arb #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          gnt_f,
  output logic          gnt_d,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arb: TIMEOUT must lie in 1..255");
  end

  state_t state, state_nxt;
  logic   owner;      // 0 = F, 1 = D
  logic   last;       // owner of the previous grant; the other side wins a tie
  logic   grant;
  logic   grant_sel;
  logic   abort;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = last;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (f_req && d_req) begin
          grant     = 1'b1;
          grant_sel = ~last;
        end else if (f_req || d_req) begin
          grant     = 1'b1;
          grant_sel = d_req;
        end
        if (grant) state_nxt = BUSY;
      end
      BUSY: begin
        // mem_rdy beats a timeout landing in the same cycle
        if (mem_rdy) begin
          state_nxt = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner     <= grant_sel;
        last      <= grant_sel;
        mem_we    <= grant_sel & d_we;
        mem_addr  <= grant_sel ? d_addr : f_addr;
        mem_wdata <= grant_sel ? d_wdata : '0;
      end
      if (abort) begin
        rdata <= '1;
      end else if (state == BUSY && mem_rdy && !mem_we) begin
        rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        tmo_cnt <= '0;
      end else if (state == BUSY && !mem_rdy) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (state == BUSY) err_q <= abort;
    end
  end

  assign err = (state == DONE) && err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_req = (state == BUSY);
  assign gnt_f   = (state != IDLE) && !owner;
  assign gnt_d   = (state != IDLE) &&  owner;
  assign f_ack   = (state == DONE) && !owner;
  assign d_ack   = (state == DONE) &&  owner;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb; a negedge monitor checks every grant and ack
// against queued expectations, scenario tasks check latency, ordering and reset behaviour.
module tb_mem_arb;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    logic          port;   // 0 = F, 1 = D
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_ack, d_ack, gnt_f, gnt_d, err;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we, mem_rdy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  txn_t sb_q[$];
  txn_t exp_t;
  logic grant_log[$];
  int   gap_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  int   req_len = 0;
  int   last_req_len = 0;
  int   ack_cnt_f = 0;
  int   ack_cnt_d = 0;
  logic mem_req_q = 1'b0;

  // memory responder controls
  int            busy_cnt = 0;
  int            rdy_lat = 1;
  logic          stray_rdy = 1'b0;
  logic          force_rdy = 1'b0;
  logic          addr_mix = 1'b0;
  logic [DW-1:0] rdata_val = '0;
  logic [DW-1:0] model_rdata = '0;

  mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .gnt_f(gnt_f), .gnt_d(gnt_d), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic txn_t mk(input logic port, input logic [AW-1:0] addr, input logic we,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rd, input logic e);
    txn_t t;
    t.port = port; t.addr = addr; t.we = we; t.wdata = wdata; t.rdata = rd; t.err = e;
    return t;
  endfunction

  // Memory model: rdy after rdy_lat BUSY cycles (0 = never), data fixed or address-derived.
  always @(negedge clk) begin
    if (mem_req) begin
      busy_cnt = busy_cnt + 1;
      mem_rdy  = force_rdy || (rdy_lat != 0 && busy_cnt == rdy_lat);
    end else begin
      busy_cnt = 0;
      mem_rdy  = stray_rdy;
    end
    mem_rdata = addr_mix ? (mem_addr ^ 8'h96) : rdata_val;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cyc = cyc + 1;
    vectors++;
    if (gnt_f && gnt_d) begin
      miscompares++;
      $display("FAIL gnt_excl: gnt_f=%b gnt_d=%b, required never both 1", gnt_f, gnt_d);
    end
    if (mem_req && !mem_req_q) begin
      grant_log.push_back(gnt_d);
      gap_q.push_back(cyc - last_ack_cyc);
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL grant: unexpected grant gnt_d=%b addr=%h, required none", gnt_d, mem_addr);
      end else begin
        exp_t = sb_q[0];
        if ({gnt_d, mem_addr, mem_we} !== {exp_t.port, exp_t.addr, exp_t.we}) begin
          miscompares++;
          $display("FAIL grant: gnt_d/addr/we=%b/%h/%b, required %b/%h/%b",
                   gnt_d, mem_addr, mem_we, exp_t.port, exp_t.addr, exp_t.we);
        end
        if (exp_t.we) begin
          vectors++;
          if (mem_wdata !== exp_t.wdata) begin
            miscompares++;
            $display("FAIL mem_wdata: got %h, required %h", mem_wdata, exp_t.wdata);
          end
        end
      end
    end
    if (mem_req) begin
      req_len = req_len + 1;
    end else if (mem_req_q) begin
      last_req_len = req_len;
      req_len = 0;
    end
    if (f_ack || d_ack) begin
      last_ack_cyc = cyc;
      if (f_ack) ack_cnt_f++;
      if (d_ack) ack_cnt_d++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL ack: unexpected ack f=%b d=%b, required none", f_ack, d_ack);
      end else begin
        exp_t = sb_q.pop_front();
        if ({f_ack, d_ack, err, rdata} !== {~exp_t.port, exp_t.port, exp_t.err, exp_t.rdata}) begin
          miscompares++;
          $display("FAIL ack: f/d/err/rdata=%b/%b/%b/%h, required %b/%b/%b/%h",
                   f_ack, d_ack, err, rdata, ~exp_t.port, exp_t.port, exp_t.err, exp_t.rdata);
        end
      end
    end
    mem_req_q = mem_req;
  end

  // Drives one request, waits (bounded) for its ack, then drops req on the following edge.
  task automatic do_txn(input logic port, input logic [AW-1:0] addr, input logic we,
                        input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdval,
                        input logic exp_err, output int req2ack, output logic [DW-1:0] rd,
                        output logic er, output bit ok);
    addr_mix  = 1'b0;
    rdy_lat   = lat;
    rdata_val = rdval;
    if (exp_err)  model_rdata = 8'hFF;
    else if (!we) model_rdata = rdval;
    sb_q.push_back(mk(port, addr, we, wdata, model_rdata, exp_err));
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    ok = 1'b0; req2ack = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      req2ack++;
      if (f_ack || d_ack) begin
        ok = 1'b1; rd = rdata; er = err;
      end
    end
    req2ack--;
    @(posedge clk); #1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({f_ack, d_ack, gnt_f, gnt_d, err, mem_req, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: f/d/gf/gd/err/req/we=%b%b%b%b%b%b%b addr=%h wdata=%h rdata=%h, required all 0",
               f_ack, d_ack, gnt_f, gnt_d, err, mem_req, mem_we, mem_addr, mem_wdata, rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: mem_req=%b, required 0", mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    int n; logic [DW-1:0] rd; logic er; bit ok; int d0;
    d0 = ack_cnt_d;
    do_txn(1'b0, 8'h10, 1'b0, 8'h00, 1, 8'hA5, 1'b0, n, rd, er, ok);
    vectors++;
    if (!ok || n != 2 || rd !== 8'hA5 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch: ok=%0d lat=%0d rdata=%h err=%b, required 1/2/a5/0", ok, n, rd, er);
    end
    vectors++;
    if (last_req_len != 1 || ack_cnt_d != d0) begin
      miscompares++;
      $display("FAIL fetch_req_len: mem_req cycles=%0d d_acks=%0d, required 1/0", last_req_len, ack_cnt_d - d0);
    end
  endtask

  task automatic test_store();
    int n; logic [DW-1:0] rd; logic er; bit ok;
    @(posedge clk); #1;
    do_txn(1'b1, 8'h3C, 1'b1, 8'h5A, 3, 8'hEE, 1'b0, n, rd, er, ok);
    vectors++;
    if (!ok || n != 4 || rd !== 8'hA5 || last_req_len != 3) begin
      miscompares++;
      $display("FAIL store: ok=%0d lat=%0d rdata=%h req_cycles=%0d, required 1/4/a5/3", ok, n, rd, last_req_len);
    end
  endtask

  task automatic test_stray_rdy();
    int n; logic [DW-1:0] rd; logic er; bit ok; int a0;
    a0 = ack_cnt_f + ack_cnt_d;
    stray_rdy = 1'b1;
    rdata_val = 8'h11;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b0 || f_ack !== 1'b0 || d_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL stray_rdy_idle: req/f/d=%b%b%b, required 000", mem_req, f_ack, d_ack);
      end
    end
    @(posedge clk); #1;
    do_txn(1'b0, 8'h44, 1'b0, 8'h00, 2, 8'h3E, 1'b0, n, rd, er, ok);
    stray_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (!ok || n != 3 || rd !== 8'h3E || (ack_cnt_f + ack_cnt_d - a0) != 1) begin
      miscompares++;
      $display("FAIL stray_rdy: ok=%0d lat=%0d rdata=%h acks=%0d, required 1/3/3e/1",
               ok, n, rd, ack_cnt_f + ack_cnt_d - a0);
    end
  endtask

  task automatic test_round_robin();
    int acks; logic was_f;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = '0;
    grant_log.delete();
    gap_q.delete();
    addr_mix = 1'b1;
    rdy_lat  = 1;
    sb_q.push_back(mk(1'b0, 8'h20, 1'b0, 8'h00, 8'hB6, 1'b0));
    sb_q.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 8'hD6, 1'b0));
    sb_q.push_back(mk(1'b0, 8'h21, 1'b0, 8'h00, 8'hB7, 1'b0));
    sb_q.push_back(mk(1'b1, 8'h41, 1'b0, 8'h00, 8'hD7, 1'b0));
    f_req = 1'b1; f_addr = 8'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40; d_wdata = 8'h00;
    acks = 0;
    for (int i = 0; i < 100 && acks < 4; i++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        acks++;
        was_f = f_ack;
        @(posedge clk); #1;
        if (acks == 4) begin
          f_req = 1'b0; d_req = 1'b0;
        end else if (was_f) begin
          f_addr = f_addr + 8'd1;
        end else begin
          d_addr = d_addr + 8'd1;
        end
      end
    end
    model_rdata = 8'hD7;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (acks != 4 || grant_log.size() != 4 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_count: acks=%0d grants=%0d mem_req=%b, required 4/4/0", acks, grant_log.size(), mem_req);
    end else begin
      vectors++;
      if ({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== 4'b0101) begin
        miscompares++;
        $display("FAIL rr_order: grants(D=1)=%b%b%b%b, required 0101",
                 grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
      end
      for (int k = 1; k < 4; k++) begin
        vectors++;
        if (gap_q[k] != 2) begin
          miscompares++;
          $display("FAIL rr_gap: ack-to-mem_req distance %0d for grant %0d, required 2", gap_q[k], k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int f0; int acks; logic was_f;
    addr_mix  = 1'b0;
    rdy_lat   = 0;
    rdata_val = 8'h99;
    sb_q.push_back(mk(1'b0, 8'h77, 1'b0, 8'h00, model_rdata, 1'b0));
    f_req = 1'b1; f_addr = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_mid_busy: mem_req=%b, required 1", mem_req);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    f_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    model_rdata = '0;
    f0 = ack_cnt_f;
    @(negedge clk);
    vectors++;
    if ({mem_req, gnt_f, f_ack, rdata} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: mem_req/gnt_f/f_ack=%b%b%b rdata=%h, required 000/00", mem_req, gnt_f, f_ack, rdata);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (ack_cnt_f != f0 || last_req_len != 2) begin
      miscompares++;
      $display("FAIL rst_mid_ack: f_acks=%0d req_cycles=%0d, required 0/2", ack_cnt_f - f0, last_req_len);
    end
    grant_log.delete();
    addr_mix = 1'b1;
    rdy_lat  = 1;
    sb_q.push_back(mk(1'b0, 8'h30, 1'b0, 8'h00, 8'hA6, 1'b0));
    sb_q.push_back(mk(1'b1, 8'h31, 1'b0, 8'h00, 8'hA7, 1'b0));
    f_req = 1'b1; f_addr = 8'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h31;
    acks = 0;
    for (int i = 0; i < 50 && acks < 2; i++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        acks++;
        was_f = f_ack;
        @(posedge clk); #1;
        if (was_f) f_req = 1'b0;
        else       d_req = 1'b0;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    model_rdata = 8'hA7;
    vectors++;
    if (acks != 2 || grant_log.size() < 1 || grant_log[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_tie: acks=%0d first grant D=%b, required 2/0", acks,
               (grant_log.size() > 0) ? grant_log[0] : 1'bx);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; logic [DW-1:0] rd; logic er; bit ok;
    @(posedge clk); #1;
    do_txn(1'b1, 8'h55, 1'b0, 8'h00, 0, 8'h12, 1'b1, n, rd, er, ok);
    vectors++;
    if (!ok || n != 16 || rd !== 8'hFF || er !== 1'b1 || last_req_len != 15) begin
      miscompares++;
      $display("FAIL timeout_abort: ok=%0d lat=%0d rdata=%h err=%b req_cycles=%0d, required 1/16/ff/1/15",
               ok, n, rd, er, last_req_len);
    end
    @(posedge clk); #1;
    do_txn(1'b1, 8'h56, 1'b0, 8'h00, 15, 8'h3D, 1'b0, n, rd, er, ok);
    vectors++;
    if (!ok || n != 16 || rd !== 8'h3D || er !== 1'b0 || last_req_len != 15) begin
      miscompares++;
      $display("FAIL timeout_race: ok=%0d lat=%0d rdata=%h err=%b req_cycles=%0d, required 1/16/3d/0/15",
               ok, n, rd, er, last_req_len);
    end
  endtask
`else
  task automatic test_timeout();
    int a0; bit acked;
    @(posedge clk); #1;
    addr_mix  = 1'b0;
    rdy_lat   = 0;
    rdata_val = 8'h6E;
    model_rdata = 8'h6E;
    sb_q.push_back(mk(1'b1, 8'h55, 1'b0, 8'h00, 8'h6E, 1'b0));
    a0 = ack_cnt_d;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h55;
    acked = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (f_ack || d_ack) acked = 1'b1;
    end
    vectors++;
    if (mem_req !== 1'b1 || acked) begin
      miscompares++;
      $display("FAIL hang_wait: mem_req=%b acked=%0d after 100 cycles, required 1/0", mem_req, acked);
    end
    @(posedge clk); #1;
    force_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (d_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL hang_rdy_cycle: d_ack=%b in mem_rdy cycle, required 0", d_ack);
    end
    @(negedge clk);
    vectors++;
    if (d_ack !== 1'b1 || err !== 1'b0 || rdata !== 8'h6E) begin
      miscompares++;
      $display("FAIL hang_release: d_ack=%b err=%b rdata=%h, required 1/0/6e", d_ack, err, rdata);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    force_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ack_cnt_d - a0 != 1) begin
      miscompares++;
      $display("FAIL hang_acks: d_acks=%0d, required 1", ack_cnt_d - a0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_stray_rdy();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected transactions left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates the single 8-bit memory port between two requesters.
  - Port F: instruction fetch, driven by ctrl.
  - Port D: data load/store.
- Runs a round-robin grant, one outstanding transaction at a time, and a req/ack handshake per requester.
- Sits between ctrl / execute datapath and the memory/bus interface; optionally detects a hung memory by timeout.

Parameters:
AW, 8, address width (bits)
DW, 8, data width (bits)
TIMEOUT, 15, cycles in BUSY without mem_rdy before abort (used only with ARB_TIMEOUT_EN; legal range 1..255)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
f_req  input  1  fetch request; held high until f_ack seen
f_addr  input  AW  fetch address; stable while f_req high
f_ack  output  1  one-cycle completion pulse to fetch
d_req  input  1  data request; held high until d_ack seen
d_we  input  1  1 = store, 0 = load; stable while d_req high
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_ack  output  1  one-cycle completion pulse to data port
rdata  output  DW  registered read data; valid while f_ack or d_ack high
gnt_f  output  1  fetch owns memory (BUSY or DONE)
gnt_d  output  1  data port owns memory (BUSY or DONE)
err  output  1  qualifies ack: transaction aborted by timeout
mem_req  output  1  memory request; high for the whole BUSY state
mem_we  output  1  latched write enable (always 0 for fetch)
mem_addr  output  AW  latched address
mem_wdata  output  DW  latched write data
mem_rdata  input  DW  memory read data; valid when mem_rdy high
mem_rdy  input  1  memory completion, sampled only in BUSY

Behaviour:
Reset values:
- State IDLE; last = D, so fetch wins the first tie.
- All outputs 0: f_ack, d_ack, gnt_f, gnt_d, err, mem_req, mem_we, mem_addr, mem_wdata, rdata.
- Timeout counter 0.

IDLE:
- Sample f_req and d_req.
- Only one requester high: grant it.
- Both high: grant the requester other than last (round-robin).
- On grant:
  - Latch owner, addr, we and wdata into the mem_* registers.
  - Set last = owner.
  - Next state BUSY.
- Neither high: stay IDLE with mem_* held at their previous values.

BUSY:
- mem_req = 1.
- mem_rdy = 1:
  - rdata <= mem_rdata for loads and fetches; rdata is unchanged for stores.
  - Next state DONE.
- A requester changing its req/addr in BUSY is a protocol violation; behaviour is undefined and it is not checked.

DONE (exactly one cycle):
- Owner's ack = 1; gnt stays on the owner; mem_req = 0.
- Next state IDLE.

Handshake:
- A requester drops req on the edge after it sees ack, so it is already low in the following IDLE cycle.
- No re-grant of a stale request.

Latency:
- req high in cycle 0 → mem_req in cycle 1.
- mem_rdy in cycle k ≥ 1 → ack in cycle k+1.
- Minimum req-to-ack is 2 cycles.
- Back-to-back transactions from the same port cost 1 IDLE cycle between them.

Other rules:
- Starvation: with both requesters asserting continuously, grants alternate F, D, F, D.
- mem_rdy outside BUSY is ignored.
- gnt_f and gnt_d are never both 1.
- Reset mid-transaction:
  - State returns to IDLE next edge; no ack is issued and mem_req drops.
  - The latched transaction is discarded.

Optional Feature:
Macro ARB_TIMEOUT_EN.

Defined:
- An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_rdy.
- When the count reaches TIMEOUT:
  - Next state DONE with err = 1 during the ack cycle.
  - rdata <= all ones (8'hFF).
- err is 0 on normal completion.
- mem_rdy in the same cycle the count reaches TIMEOUT wins: normal completion, err = 0.

Undefined:
- No counter; BUSY waits indefinitely for mem_rdy.
- err is tied to 0.

Test Plan:
- Reset then single fetch: f_req=1, f_addr=8'h10, mem_rdy on the first BUSY cycle with mem_rdata=8'hA5 → mem_req for 1 cycle, mem_addr=8'h10, mem_we=0, f_ack pulse 1 cycle later, rdata=8'hA5, d_ack never asserts.
- Simultaneous requests after reset, held continuously for 4 transactions → grant order F, D, F, D; gnt_f and gnt_d never both 1; one IDLE cycle between each ack and the next mem_req.
- Store: d_req=1, d_we=1, d_addr=8'h3C, d_wdata=8'h5A, mem_rdy after 3 BUSY cycles → mem_we=1, mem_wdata=8'h5A, mem_req high 3 cycles, d_ack pulse, rdata unchanged.
- Reset asserted in the 2nd BUSY cycle of a fetch → next cycle mem_req=0, gnt_f=0, f_ack never pulses; the next tie grants F.
- With ARB_TIMEOUT_EN and TIMEOUT=15: d_req load, mem_rdy held 0 → mem_req high exactly 15 cycles, then d_ack=1 with err=1, rdata=8'hFF. Repeat with mem_rdy in the 15th cycle → err=0, rdata=mem_rdata.
- Without ARB_TIMEOUT_EN: same stimulus with mem_rdy low for 100 cycles → mem_req stays high, no ack. Assert mem_rdy → ack next cycle, err=0.
